imem_boot_loader: RTL



---
 rtl/imem_boot_pkg.sv | 26 ++
 rtl/imem_boot_loader_byte_packer.sv | 38 +++
 rtl/imem_boot_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/imem_boot_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
package imem_boot_pkg;

    // Loader phases: header collection, payload load, checksum compare,
    // core released, and the sticky failure state.
    typedef enum logic [2:0] {
        COUNT = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;

    // Running image checksum: plain XOR of every payload word.
    function automatic logic [31:0] xor_fold(input logic [31:0] acc, input logic [31:0] w);
        return acc ^ w;
    endfunction

    // Header word count is judged on all 32 bits against memory capacity.
    function automatic logic count_exceeds(input logic [31:0] n, input int unsigned addr_w);
        return (n > (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs an accepted byte stream into 32-bit big-endian words.
// word_valid is a combinational pulse in the cycle the 4th byte is accepted,
// so the owner can act on that same clock edge.
module byte_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  count_r;
    logic [23:0] shift_r;

    assign word_valid = byte_valid && (count_r == LAST_BYTE);
    assign word       = {shift_r, byte_data};

    // Byte position counter and the first three bytes of the current word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 2'd0;
            shift_r <= 24'd0;
        end else if (clear) begin
            count_r <= 2'd0;
            shift_r <= 24'd0;
        end else if (byte_valid) begin
            count_r <= count_r + 2'd1;
            shift_r <= {shift_r[15:0], byte_data};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a byte-streamed program image, writes it into
// instruction memory, verifies the XOR checksum and releases the core.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] WL_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_r;
    state_t              next_state_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                restart_s;
    logic                clear_s;
    logic                word_valid_s;
    logic [31:0]         word_s;
    logic                last_word_s;
    logic [31:0]         n_r;
    logic [31:0]         xor_r;
    logic [ADDR_W:0]     wl_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic                run_r;
    logic                err_r;

    assign accept_s    = in_valid && in_ready_s;
    assign restart_s   = restart && ((state_r == RUN) || (state_r == ERR));
    assign clear_s     = restart_s || (next_state_s != state_r);
    assign last_word_s = ((32'(wl_r) + 32'd1) == n_r);

    assign in_ready     = in_ready_s;
    assign imem_we      = we_r;
    assign imem_addr    = addr_r;
    assign imem_wdata   = wdata_r;
    assign core_run     = run_r;
    assign load_error   = err_r;
    assign words_loaded = wl_r;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_s),
        .byte_valid (accept_s),
        .byte_data  (in_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Ready depends on state alone so the source never sees a loop through in_valid.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            COUNT, LOAD, CHECK: in_ready_s = 1'b1;
            default:            in_ready_s = 1'b0;
        endcase
    end

    // Next-state decision; every transition lands on the edge that completes a word.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            COUNT: begin
                if (word_valid_s) begin
                    if (count_exceeds(word_s, ADDR_W)) begin
                        next_state_s = ERR;
                    end else if (word_s == 32'd0) begin
                        next_state_s = CHECK;
                    end else begin
                        next_state_s = LOAD;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            LOAD: begin
                if (word_valid_s && last_word_s) begin
                    next_state_s = CHECK;
                end else begin
                    next_state_s = state_r;
                end
            end
            CHECK: begin
                if (word_valid_s) begin
                    if (word_s == xor_r) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = ERR;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            RUN, ERR: begin
                if (restart) begin
                    next_state_s = COUNT;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = COUNT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= COUNT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Status flags follow the state being entered, so core_run rises on the
    // edge that accepts the final checksum byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            run_r <= (next_state_s == RUN);
            err_r <= (next_state_s == ERR);
        end
    end

    // Header count, running checksum, word counter and the memory write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_r     <= 32'd0;
            xor_r   <= 32'd0;
            wl_r    <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 32'd0;
        end else begin
            we_r <= 1'b0;
            if (restart_s) begin
                n_r    <= 32'd0;
                xor_r  <= 32'd0;
                wl_r   <= '0;
                addr_r <= '0;
            end else if (word_valid_s && (state_r == COUNT)) begin
                n_r <= word_s;
            end else if (word_valid_s && (state_r == LOAD)) begin
                we_r    <= 1'b1;
                addr_r  <= wl_r[ADDR_W-1:0];
                wdata_r <= word_s;
                wl_r    <= wl_r + WL_ONE;
                xor_r   <= xor_fold(xor_r, word_s);
            end
        end
    end

endmodule
